// File: rtl/alu_pkg.sv
// Shared ALU/MDU definitions: operation codes, FSM states, default width.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_AND   = 5'd2,
    OP_OR    = 5'd3,
    OP_NOT   = 5'd4,
    OP_XOR   = 5'd5,
    OP_SLL   = 5'd6,
    OP_SRL   = 5'd7,
    OP_SRA   = 5'd8,
    OP_SLT   = 5'd9,
    OP_SLTU  = 5'd10,
    OP_SEQ   = 5'd11,
    OP_SGT   = 5'd12,
    OP_LUI   = 5'd13,
    OP_MULT  = 5'd14,
    OP_MULTU = 5'd15,
    OP_MADD  = 5'd16,
    OP_MADDU = 5'd17,
    OP_DIV   = 5'd18,
    OP_DIVU  = 5'd19,
    OP_MFHI  = 5'd20,
    OP_MFLO  = 5'd21,
    OP_MTHI  = 5'd22,
    OP_MTLO  = 5'd23
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_e;

endpackage

// File: rtl/alu_mdu_if.sv
// Request/response bus of alu_mdu.
//   slave : the ALU/MDU (accepts in_valid/op/a/b, returns result/flags, shows hi/lo)
//   master: the requester
interface alu_mdu_if #(
  parameter int unsigned WIDTH = alu_pkg::ALU_WIDTH
) ();
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             div_zero;
  logic             illegal;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, div_zero, illegal, hi, lo
  );

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, div_zero, illegal, hi, lo
  );
endinterface

// File: rtl/alu_mdu_iter.sv
// Iterative multiply/divide datapath on unsigned magnitudes, one bit per step.
//   start/mode_div/mag_a/mag_b : load operands (multiplier or dividend in mag_a)
//   step                       : perform one iteration
//   last                       : the current step is the final one
//   prod/quot/rem              : values after the current step
module alu_mdu_iter import alu_pkg::*; #(
  parameter int unsigned WIDTH = ALU_WIDTH,
  localparam int unsigned CW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode_div,
  input  logic [WIDTH-1:0]   mag_a,
  input  logic [WIDTH-1:0]   mag_b,
  input  logic               step,
  output logic               last,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   quot,
  output logic [WIDTH-1:0]   rem
);
  logic [WIDTH:0]   acc, acc_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [WIDTH-1:0] opnd;
  logic [CW-1:0]    cnt;
  logic             div_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rs;
  logic [WIDTH+1:0] diff;

  // Multiply: {acc,sh} shifts right, adding the multiplicand on sh[0].
  // Divide: {acc,sh} shifts left, quotient bits enter at sh[0].
  always_comb begin
    acc_n = acc;
    sh_n  = sh;
    sum   = '0;
    rs    = '0;
    diff  = '0;
    if (div_q) begin
      rs   = {acc[WIDTH-1:0], sh[WIDTH-1]};
      diff = {1'b0, rs} - {2'b00, opnd};
      if (diff[WIDTH+1]) begin
        acc_n = rs;
        sh_n  = {sh[WIDTH-2:0], 1'b0};
      end else begin
        acc_n = diff[WIDTH:0];
        sh_n  = {sh[WIDTH-2:0], 1'b1};
      end
    end else begin
      sum   = acc + (sh[0] ? {1'b0, opnd} : '0);
      acc_n = {1'b0, sum[WIDTH:1]};
      sh_n  = {sum[0], sh[WIDTH-1:1]};
    end
  end

  assign last = (cnt == CW'(WIDTH - 1));
  assign prod = {acc_n[WIDTH-1:0], sh_n};
  assign quot = sh_n;
  assign rem  = acc_n[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      sh    <= '0;
      opnd  <= '0;
      cnt   <= '0;
      div_q <= 1'b0;
    end else if (start) begin
      acc   <= '0;
      sh    <= mag_a;
      opnd  <= mag_b;
      cnt   <= '0;
      div_q <= mode_div;
    end else if (step) begin
      acc   <= acc_n;
      sh    <= sh_n;
      cnt   <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/alu_mdu.sv
// ALU with multiply/divide unit and HI/LO registers.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request (in_valid/in_ready/op/a/b), response
//                (out_valid/out_ready/result/div_zero/illegal), hi/lo view
module alu_mdu import alu_pkg::*; #(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_mdu_if.slave   bus
);
  state_e             state;
  logic               run;
  logic               out_valid_q, div_zero_q, illegal_q;
  logic [WIDTH-1:0]   result_q, hi_q, lo_q;
  logic               neg_q, neg_r, madd_q;

  logic               accept;
  logic [WIDTH-1:0]   sc_result;
  logic               sc_dz, sc_ill;
  logic               is_mul, is_div, is_signed, iterative;
  logic [WIDTH-1:0]   mag_a, mag_b;

  logic               iter_last;
  logic [2*WIDTH-1:0] iter_prod, prod_s, mul_hilo;
  logic [WIDTH-1:0]   iter_quot, iter_rem, quot_s, rem_s;

  // run holds in_ready low until the first edge after reset release.
  assign bus.in_ready  = run && ((state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.illegal   = illegal_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

  always_comb begin
    sc_result = '0;
    sc_dz     = 1'b0;
    sc_ill    = 1'b0;
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    case (bus.op)
      OP_ADD:   sc_result = bus.a + bus.b;
      OP_SUB:   sc_result = bus.a - bus.b;
      OP_AND:   sc_result = bus.a & bus.b;
      OP_OR:    sc_result = bus.a | bus.b;
      OP_NOT:   sc_result = ~bus.a;
      OP_XOR:   sc_result = bus.a ^ bus.b;
      OP_SLL:   sc_result = bus.a << bus.b[SHW-1:0];
      OP_SRL:   sc_result = bus.a >> bus.b[SHW-1:0];
      OP_SRA:   sc_result = WIDTH'($signed(bus.a) >>> bus.b[SHW-1:0]);
      OP_SLT:   sc_result = WIDTH'($signed(bus.a) < $signed(bus.b));
      OP_SLTU:  sc_result = WIDTH'(bus.a < bus.b);
      OP_SEQ:   sc_result = WIDTH'(bus.a == bus.b);
      OP_SGT:   sc_result = WIDTH'(bus.a > bus.b);
      OP_LUI: begin
        if (WIDTH >= 32) sc_result = (bus.a + bus.b) << 16;
        else             sc_ill    = 1'b1;
      end
      OP_MULT, OP_MADD: begin
        is_mul    = 1'b1;
        is_signed = 1'b1;
      end
      OP_MULTU, OP_MADDU: is_mul = 1'b1;
      OP_DIV: begin
        is_div    = 1'b1;
        is_signed = 1'b1;
      end
      OP_DIVU:  is_div    = 1'b1;
      OP_MFHI:  sc_result = hi_q;
      OP_MFLO:  sc_result = lo_q;
      OP_MTHI:  sc_result = bus.a;
      OP_MTLO:  sc_result = bus.a;
      default:  sc_ill    = 1'b1;
    endcase
    sc_dz     = is_div && (bus.b == '0);
    iterative = is_mul || (is_div && (bus.b != '0));
    mag_a     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    mag_b     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  alu_mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (accept && iterative),
    .mode_div (is_div),
    .mag_a    (mag_a),
    .mag_b    (mag_b),
    .step     ((state == ST_MUL) || (state == ST_DIV)),
    .last     (iter_last),
    .prod     (iter_prod),
    .quot     (iter_quot),
    .rem      (iter_rem)
  );

  // Sign correction applied to the final-step values so hi/lo land on the same edge as out_valid.
  always_comb begin
    prod_s   = neg_q ? -iter_prod : iter_prod;
    mul_hilo = madd_q ? ({hi_q, lo_q} + prod_s) : prod_s;
    quot_s   = neg_q ? -iter_quot : iter_quot;
    rem_s    = neg_r ? -iter_rem : iter_rem;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      run         <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      div_zero_q  <= 1'b0;
      illegal_q   <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      madd_q      <= 1'b0;
    end else begin
      run <= 1'b1;
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
        state       <= ST_IDLE;
      end
      if (accept) begin
        neg_q  <= is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        neg_r  <= is_signed && bus.a[WIDTH-1];
        madd_q <= (bus.op == OP_MADD) || (bus.op == OP_MADDU);
        if (is_mul) begin
          state <= ST_MUL;
        end else if (iterative) begin
          state <= ST_DIV;
        end else begin
          state       <= ST_DONE;
          out_valid_q <= 1'b1;
          result_q    <= sc_result;
          div_zero_q  <= sc_dz;
          illegal_q   <= sc_ill;
          if (bus.op == OP_MTHI) hi_q <= bus.a;
          if (bus.op == OP_MTLO) lo_q <= bus.a;
        end
      end
      case (state)
        ST_MUL: if (iter_last) begin
          state        <= ST_DONE;
          out_valid_q  <= 1'b1;
          {hi_q, lo_q} <= mul_hilo;
          result_q     <= mul_hilo[WIDTH-1:0];
          div_zero_q   <= 1'b0;
          illegal_q    <= 1'b0;
        end
        ST_DIV: if (iter_last) begin
          state       <= ST_DONE;
          out_valid_q <= 1'b1;
          hi_q        <= rem_s;
          lo_q        <= quot_s;
          result_q    <= quot_s;
          div_zero_q  <= 1'b0;
          illegal_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed vectors, random ops against a
// behavioural model, reset abort, and a 16-bit build.
module tb_alu_mdu;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  logic [31:0] m_hi, m_lo;
  logic [31:0] obs_res, obs_hi, obs_lo;
  logic        obs_dz, obs_ill;
  int          obs_lat;

  alu_mdu_if #(.WIDTH(32)) b32 ();
  alu_mdu_if #(.WIDTH(16)) b16 ();

  alu_mdu #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
  alu_mdu #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from plain arithmetic; updates model hi/lo.
  task automatic model32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic dz, output logic il, output int lat);
    logic [63:0] p, hl;
    logic [31:0] q, rm;
    r = '0; dz = 1'b0; il = 1'b0; lat = 1; hl = {m_hi, m_lo};
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOT:  r = ~a;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = a >> b[4:0];
      OP_SRA:  r = $signed(a) >>> b[4:0];
      OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      OP_SEQ:  r = (a == b) ? 32'd1 : 32'd0;
      OP_SGT:  r = (a > b) ? 32'd1 : 32'd0;
      OP_LUI:  r = (a + b) << 16;
      OP_MULT, OP_MADD, OP_MULTU, OP_MADDU: begin
        if (op == OP_MULT || op == OP_MADD) p = 64'(longint'($signed(a)) * longint'($signed(b)));
        else                                p = {32'd0, a} * {32'd0, b};
        hl  = (op == OP_MADD || op == OP_MADDU) ? hl + p : p;
        r   = hl[31:0];
        lat = 33;
      end
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) begin
          dz = 1'b1;
        end else begin
          if (op == OP_DIVU) begin
            q = a / b; rm = a % b;
          end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; rm = '0;
          end else begin
            q = $signed(a) / $signed(b); rm = $signed(a) % $signed(b);
          end
          hl  = {rm, q};
          r   = q;
          lat = 33;
        end
      end
      OP_MFHI: r = m_hi;
      OP_MFLO: r = m_lo;
      OP_MTHI: begin r = a; hl[63:32] = a; end
      OP_MTLO: begin r = a; hl[31:0] = a; end
      default: il = 1'b1;
    endcase
    {m_hi, m_lo} = hl;
  endtask

  task automatic run32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] er;
    logic        edz, eil;
    int          elat, n;
    model32(op, a, b, er, edz, eil, elat);
    @(negedge clk);
    n = 0;
    while (!b32.in_ready && n < 100) begin @(negedge clk); n++; end
    chk("in_ready_before_req", b32.in_ready, 1);
    b32.op = op; b32.a = a; b32.b = b; b32.in_valid = 1'b1;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    n = 1;
    while (!b32.out_valid && n < 100) begin @(posedge clk); #1; n++; end
    obs_lat = n; obs_res = b32.result; obs_hi = b32.hi; obs_lo = b32.lo;
    obs_dz = b32.div_zero; obs_ill = b32.illegal;
    chk("latency", obs_lat, elat);
    chk("result", obs_res, er);
    chk("div_zero", obs_dz, edz);
    chk("illegal", obs_ill, eil);
    chk("hi", obs_hi, m_hi);
    chk("lo", obs_lo, m_lo);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_result", b32.result, er);
      chk("hold_valid", b32.out_valid, 1);
      chk("hold_in_ready", b32.in_ready, 0);
    end
    @(negedge clk);
    b32.out_ready = 1'b1;
    @(posedge clk); #1;
    b32.out_ready = 1'b0;
    chk("valid_dropped", b32.out_valid, 0);
  endtask

  task automatic run16(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input int elat, input logic eil,
                       input logic [15:0] ehi, input logic [15:0] elo);
    int n;
    @(negedge clk);
    n = 0;
    while (!b16.in_ready && n < 100) begin @(negedge clk); n++; end
    b16.op = op; b16.a = a; b16.b = b; b16.in_valid = 1'b1;
    @(posedge clk); #1;
    b16.in_valid = 1'b0;
    n = 1;
    while (!b16.out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("w16_latency", n, elat);
    chk("w16_result", b16.result, er);
    chk("w16_illegal", b16.illegal, eil);
    chk("w16_hi", b16.hi, ehi);
    chk("w16_lo", b16.lo, elo);
    @(negedge clk);
    b16.out_ready = 1'b1;
    @(posedge clk); #1;
    b16.out_ready = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] sp [5];
    sp[0] = 32'h0; sp[1] = 32'hFFFF_FFFF; sp[2] = 32'h8000_0000; sp[3] = 32'h1; sp[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    return $urandom();
  endfunction

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    m_hi = '0; m_lo = '0;
    b32.in_valid = 1'b0; b32.op = '0; b32.a = '0; b32.b = '0; b32.out_ready = 1'b0;
    b16.in_valid = 1'b0; b16.op = '0; b16.a = '0; b16.b = '0; b16.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", b32.out_valid, 0);
    chk("rst_result", b32.result, 0);
    chk("rst_hi", b32.hi, 0);
    chk("rst_lo", b32.lo, 0);
    chk("rst_div_zero", b32.div_zero, 0);
    chk("rst_illegal", b32.illegal, 0);
    chk("rst_in_ready", b32.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_first_edge", b32.in_ready, 0);
    @(posedge clk); #1;
    chk("in_ready_after_first_edge", b32.in_ready, 1);

    run32(OP_ADD, 32'hFFFF_FFFF, 32'h1, 0);
    chk("add_wrap_result", obs_res, 32'h0);
    chk("add_wrap_latency", obs_lat, 1);

    run32(OP_MULT, 32'hFFFF_FFFD, 32'd7, 0);
    chk("mult_latency", obs_lat, 33);
    chk("mult_hi", obs_hi, 32'hFFFF_FFFF);
    chk("mult_lo", obs_lo, 32'hFFFF_FFEB);
    chk("mult_result", obs_res, 32'hFFFF_FFEB);
    run32(OP_MADDU, 32'd2, 32'd3, 0);
    chk("maddu_lo", obs_lo, 32'hFFFF_FFF1);
    chk("maddu_hi", obs_hi, 32'hFFFF_FFFF);

    run32(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div_lo", obs_lo, 32'hFFFF_FFFD);
    chk("div_hi", obs_hi, 32'hFFFF_FFFF);
    run32(OP_DIVU, 32'd7, 32'd0, 0);
    chk("divz_flag", obs_dz, 1);
    chk("divz_result", obs_res, 32'h0);
    chk("divz_latency", obs_lat, 1);
    chk("divz_lo_kept", obs_lo, 32'hFFFF_FFFD);
    chk("divz_hi_kept", obs_hi, 32'hFFFF_FFFF);

    run32(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("div_ovf_lo", obs_lo, 32'h8000_0000);
    chk("div_ovf_hi", obs_hi, 32'h0);

    run32(OP_SRA, 32'h8000_0000, 32'h24, 5);
    chk("sra_result", obs_res, 32'hF800_0000);

    run32(OP_LUI, 32'h0000_1234, 32'h0000_0001, 0);
    run32(OP_MTHI, 32'hCAFE_F00D, 32'h0, 0);
    run32(OP_MFHI, 32'h0, 32'h0, 0);
    run32(OP_MTLO, 32'h1234_5678, 32'h0, 0);
    run32(OP_MFLO, 32'h0, 32'h0, 0);
    run32(5'd31, 32'h5, 32'h6, 0);
    chk("illegal_flag", obs_ill, 1);

    for (int i = 0; i < 40; i++) begin
      run32(5'($urandom_range(0, 27)), pick(), pick(), $urandom_range(0, 2));
    end

    // Abort a MULTU with reset part way through.
    @(negedge clk);
    b32.op = OP_MULTU; b32.a = 32'h1234_5678; b32.b = 32'h9ABC_DEF0; b32.in_valid = 1'b1;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    chk("abort_hi", b32.hi, 0);
    chk("abort_lo", b32.lo, 0);
    chk("abort_out_valid", b32.out_valid, 0);
    chk("abort_in_ready", b32.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run32(OP_ADD, 32'd2, 32'd2, 0);
    chk("post_abort_add", obs_res, 32'd4);
    chk("post_abort_latency", obs_lat, 1);

    run16(OP_DIVU, 16'hFFFF, 16'h0003, 16'h5555, 17, 1'b0, 16'h0000, 16'h5555);
    run16(5'd31, 16'h0001, 16'h0002, 16'h0000, 1, 1'b1, 16'h0000, 16'h5555);
    run16(OP_MULT, 16'hFFFE, 16'h0003, 16'hFFFA, 17, 1'b0, 16'hFFFF, 16'hFFFA);
    run16(OP_LUI, 16'h0001, 16'h0001, 16'h0000, 1, 1'b1, 16'hFFFF, 16'hFFFA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
